// File: rtl/arbiter_client_pkg.sv
// Shared definitions for the arbiter requester side: grant encodings and
// the per-client channel state machine encoding.
package arbiter_client_pkg;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_C0   = 2'b01;
  localparam logic [1:0] GNT_C1   = 2'b10;
  localparam logic [1:0] GNT_C2   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_REQ     = 2'b01,
    ST_HOLD    = 2'b10,
    ST_RELEASE = 2'b11
  } chanState_e;

  function automatic logic [1:0] gntFor(input int unsigned idx);
    case (idx)
      0:       return GNT_C0;
      1:       return GNT_C1;
      default: return GNT_C2;
    endcase
  endfunction

endpackage

// File: rtl/arbiter_client_if.sv
// Job-source / arbiter-facing signal bundle of the requester block.
// The master side is the requester itself; the slave side is its environment.
interface arbiter_client_if #(
  parameter int CNT_W = 3
);

  logic [2:0]         job_valid;
  logic [2:0]         job_ready;
  logic [1:0]         grant_q;
  logic [2:0]         req;
  logic [2:0]         busy;
  logic [2:0]         done;
  logic [3*CNT_W-1:0] pending;
  logic               timeout_err;
  logic               proto_err;

  modport master (
    input  job_valid, grant_q,
    output job_ready, req, busy, done, pending, timeout_err, proto_err
  );

  modport slave (
    output job_valid, grant_q,
    input  job_ready, req, busy, done, pending, timeout_err, proto_err
  );

endinterface

// File: rtl/arbiter_client_chan.sv
// One client's request channel: pending-job counter, IDLE/REQ/HOLD/RELEASE
// FSM, hold and wait counters, and per-cycle protocol/timeout events.
module arbiter_client_chan
  import arbiter_client_pkg::*;
#(
  parameter int unsigned IDX         = 0,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 15,
  parameter int unsigned CNT_W       = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             jobValid_i,
  input  logic [1:0]       grant_i,
  output logic             jobReady_o,
  output logic             req_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] pending_o,
  output logic             timeoutEv_o,
  output logic             protoEv_o
);

  localparam logic [1:0]       MY_GNT    = gntFor(IDX);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [3:0]       HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [7:0]       WAIT_MAX  = 8'(TIMEOUT);

  chanState_e       state_q, state_d;
  logic [3:0]       holdCnt_q, holdCnt_d;
  logic [7:0]       waitCnt_q, waitCnt_d;
  logic [CNT_W-1:0] pendCnt_q, pendCnt_d;
  logic             releaseGuard_q, releaseGuard_d;
  logic             mine;
  logic             enq;
  logic             deq;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      holdCnt_q      <= '0;
      waitCnt_q      <= '0;
      pendCnt_q      <= '0;
      releaseGuard_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      holdCnt_q      <= holdCnt_d;
      waitCnt_q      <= waitCnt_d;
      pendCnt_q      <= pendCnt_d;
      releaseGuard_q <= releaseGuard_d;
    end
  end

  // The arbiter's registered grant trails our req by a cycle, so a grant seen
  // in the IDLE cycle right after RELEASE is tolerated (releaseGuard_q).
  always_comb begin
    state_d        = state_q;
    holdCnt_d      = holdCnt_q;
    waitCnt_d      = waitCnt_q;
    releaseGuard_d = (state_q == ST_RELEASE);
    protoEv_o      = 1'b0;
    deq            = 1'b0;
    mine           = (grant_i == MY_GNT);

    case (state_q)
      ST_IDLE: begin
        waitCnt_d = '0;
        if (mine && !releaseGuard_q) protoEv_o = 1'b1;
        if (pendCnt_q != '0) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (mine) begin
          state_d   = ST_HOLD;
          holdCnt_d = HOLD_LOAD;
          waitCnt_d = '0;
        end else if (waitCnt_q != WAIT_MAX) begin
          waitCnt_d = waitCnt_q + 8'd1;
        end
      end
      ST_HOLD: begin
        if (!mine) begin
          protoEv_o = 1'b1;
          state_d   = ST_REQ;
          waitCnt_d = '0;
        end else if (holdCnt_q == 4'd0) begin
          state_d = ST_RELEASE;
          deq     = 1'b1;
        end else begin
          holdCnt_d = holdCnt_q - 4'd1;
        end
      end
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    enq       = jobValid_i && (pendCnt_q != CNT_MAX);
    pendCnt_d = pendCnt_q;
    if (enq && !deq)      pendCnt_d = pendCnt_q + 1'b1;
    else if (!enq && deq) pendCnt_d = pendCnt_q - 1'b1;
  end

  assign req_o       = (state_q == ST_REQ) || (state_q == ST_HOLD);
  assign busy_o      = (state_q == ST_HOLD);
  assign done_o      = (state_q == ST_RELEASE);
  assign jobReady_o  = (pendCnt_q != CNT_MAX);
  assign pending_o   = pendCnt_q;
  assign timeoutEv_o = (state_q == ST_REQ) && (waitCnt_q == WAIT_MAX);

endmodule

// File: rtl/arbiter_client.sv
// Requester side of the three-way Moore arbiter: three independent client
// channels plus sticky timeout and grant-protocol error flags.
module arbiter_client
  import arbiter_client_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned TIMEOUT     = 15,
  parameter int unsigned CNT_W       = 3
) (
  input  logic                clk,
  input  logic                rst,
  arbiter_client_if.master    bus
);

  logic [2:0]         reqVec;
  logic [2:0]         busyVec;
  logic [2:0]         doneVec;
  logic [2:0]         readyVec;
  logic [2:0]         timeoutEv;
  logic [2:0]         protoEv;
  logic [3*CNT_W-1:0] pendVec;
  logic               timeoutErr_q, timeoutErr_d;
  logic               protoErr_q, protoErr_d;

  for (genvar i = 0; i < 3; i++) begin : g_chan
    arbiter_client_chan #(
      .IDX         (i),
      .HOLD_CYCLES (HOLD_CYCLES),
      .TIMEOUT     (TIMEOUT),
      .CNT_W       (CNT_W)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .jobValid_i  (bus.job_valid[i]),
      .grant_i     (bus.grant_q),
      .jobReady_o  (readyVec[i]),
      .req_o       (reqVec[i]),
      .busy_o      (busyVec[i]),
      .done_o      (doneVec[i]),
      .pending_o   (pendVec[i*CNT_W +: CNT_W]),
      .timeoutEv_o (timeoutEv[i]),
      .protoEv_o   (protoEv[i])
    );
  end

  always_comb begin
    timeoutErr_d = timeoutErr_q | (|timeoutEv);
    protoErr_d   = protoErr_q | (|protoEv);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timeoutErr_q <= 1'b0;
      protoErr_q   <= 1'b0;
    end else begin
      timeoutErr_q <= timeoutErr_d;
      protoErr_q   <= protoErr_d;
    end
  end

  assign bus.req         = reqVec;
  assign bus.busy        = busyVec;
  assign bus.done        = doneVec;
  assign bus.job_ready   = readyVec;
  assign bus.pending     = pendVec;
  assign bus.timeout_err = timeoutErr_q;
  assign bus.proto_err   = protoErr_q;

endmodule

// File: tb/tb_arbiter_client.sv
// Scoreboard bench for arbiter_client: directed scenarios push expected
// per-cycle values and done pulses; a negedge monitor pops and compares.
module tb_arbiter_client;
  import arbiter_client_pkg::*;

  localparam int CNT_W = 3;

  typedef enum int {F_REQ, F_BUSY, F_DONE, F_PEND, F_READY, F_TMO, F_PROTO} field_e;
  typedef struct { int cyc; field_e sel; int val; string name; } exp_t;
  typedef struct { int cyc; logic [2:0] val; } done_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   base = 0;
  int   total = 0;
  int   bad = 0;
  exp_t  expQ[$];
  done_t doneQ[$];

  arbiter_client_if #(.CNT_W(CNT_W)) bus ();

  arbiter_client #(
    .HOLD_CYCLES (4),
    .TIMEOUT     (15),
    .CNT_W       (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] fieldOf(input field_e s);
    case (s)
      F_REQ:   return 32'(bus.req);
      F_BUSY:  return 32'(bus.busy);
      F_DONE:  return 32'(bus.done);
      F_PEND:  return 32'(bus.pending);
      F_READY: return 32'(bus.job_ready);
      F_TMO:   return 32'(bus.timeout_err);
      F_PROTO: return 32'(bus.proto_err);
      default: return 32'hdead_beef;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input int want,
                             input int gotCyc, input int wantCyc);
    total++;
    if (got !== 32'(want) || gotCyc != wantCyc) begin
      bad++;
      $display("[TB] FAIL %s: got %0d at cycle %0d, want %0d at cycle %0d",
               name, got, gotCyc - base, want, wantCyc - base);
    end
  endtask

  task automatic pushExp(input int rel, input field_e sel, input int val, input string name);
    exp_t e;
    e.cyc = base + rel; e.sel = sel; e.val = val; e.name = name;
    expQ.push_back(e);
  endtask

  task automatic pushDone(input int rel, input logic [2:0] val);
    done_t d;
    d.cyc = base + rel; d.val = val;
    doneQ.push_back(d);
  endtask

  task automatic pushResetVals(input int rel, input string tag);
    pushExp(rel, F_REQ,   0, {tag, "_req"});
    pushExp(rel, F_BUSY,  0, {tag, "_busy"});
    pushExp(rel, F_DONE,  0, {tag, "_done"});
    pushExp(rel, F_PEND,  0, {tag, "_pending"});
    pushExp(rel, F_READY, 7, {tag, "_job_ready"});
    pushExp(rel, F_TMO,   0, {tag, "_timeout_err"});
    pushExp(rel, F_PROTO, 0, {tag, "_proto_err"});
  endtask

  // Inputs are driven at a negedge and held for one full cycle.
  task automatic applyStimulus(input logic r, input logic [2:0] jv, input logic [1:0] gq);
    rst           = r;
    bus.job_valid = jv;
    bus.grant_q   = gq;
    @(negedge clk);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 3'b000, GNT_NONE);
    base = cyc;
  endtask

  // Monitor: timed expectations and done-pulse scoreboard.
  always @(negedge clk) begin
    done_t d;
    for (int i = expQ.size() - 1; i >= 0; i--) begin
      if (expQ[i].cyc <= cyc) begin
        checkOutput(expQ[i].name, fieldOf(expQ[i].sel), expQ[i].val, cyc, expQ[i].cyc);
        expQ.delete(i);
      end
    end
    if (bus.done != 3'b000) begin
      if (doneQ.size() == 0) begin
        checkOutput("unexpected_done", 32'(bus.done), 0, cyc, cyc);
      end else begin
        d = doneQ.pop_front();
        checkOutput("done_pulse", 32'(bus.done), int'(d.val), cyc, d.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.job_valid = 3'b000;
    bus.grant_q   = GNT_NONE;

    // Single job on client0, grant held two cycles past release.
    doReset();
    pushResetVals(1, "A_reset");
    pushExp(2, F_PEND, 1, "A_pend_enq");
    pushExp(2, F_REQ, 0, "A_req_not_yet");
    pushExp(3, F_REQ, 1, "A_req_rise");
    pushExp(3, F_BUSY, 0, "A_busy_not_yet");
    pushExp(4, F_BUSY, 1, "A_busy_first");
    pushExp(7, F_BUSY, 1, "A_busy_last");
    pushExp(7, F_PEND, 1, "A_pend_in_hold");
    pushExp(8, F_REQ, 0, "A_req_release");
    pushExp(8, F_BUSY, 0, "A_busy_release");
    pushExp(8, F_PEND, 0, "A_pend_deq");
    pushDone(8, 3'b001);
    pushExp(9, F_DONE, 0, "A_done_one_cycle");
    pushExp(11, F_PROTO, 0, "A_late_grant_exempt");
    for (int r = 0; r <= 12; r++)
      applyStimulus(1'b0, (r == 1) ? 3'b001 : 3'b000,
                    (r >= 3 && r <= 9) ? GNT_C0 : GNT_NONE);

    // Contention: all three clients, grants served in order 0,1,2.
    doReset();
    pushExp(2, F_PEND, 73, "B_pend_all");
    pushExp(3, F_REQ, 7, "B_req_all");
    pushExp(5, F_BUSY, 1, "B_busy0");
    pushExp(8, F_REQ, 6, "B_req_drop0");
    pushExp(8, F_PEND, 72, "B_pend_after0");
    pushExp(10, F_BUSY, 2, "B_busy1");
    pushExp(13, F_REQ, 4, "B_req_drop1");
    pushExp(13, F_PEND, 64, "B_pend_after1");
    pushExp(15, F_BUSY, 4, "B_busy2");
    pushExp(18, F_REQ, 0, "B_req_drop2");
    pushExp(18, F_PEND, 0, "B_pend_after2");
    pushExp(19, F_PROTO, 0, "B_no_proto");
    pushExp(19, F_TMO, 0, "B_no_timeout");
    pushDone(8, 3'b001);
    pushDone(13, 3'b010);
    pushDone(18, 3'b100);
    for (int r = 0; r <= 21; r++)
      applyStimulus(1'b0, (r == 1) ? 3'b111 : 3'b000,
                    (r >= 3 && r <= 7)   ? GNT_C0 :
                    (r >= 8 && r <= 12)  ? GNT_C1 :
                    (r >= 13 && r <= 17) ? GNT_C2 : GNT_NONE);

    // Overflow: eight jobs on client1, the eighth is dropped.
    doReset();
    pushExp(7, F_PEND, 48, "C_pend6");
    pushExp(7, F_READY, 7, "C_ready_not_full");
    pushExp(8, F_PEND, 56, "C_pend7");
    pushExp(8, F_READY, 5, "C_ready_full");
    pushExp(10, F_PEND, 56, "C_no_wrap");
    pushExp(10, F_READY, 5, "C_ready_stays_low");
    for (int r = 0; r <= 11; r++)
      applyStimulus(1'b0, (r >= 1 && r <= 8) ? 3'b010 : 3'b000, GNT_NONE);

    // Timeout: client2 requests with no grant.
    doReset();
    pushExp(3, F_REQ, 4, "D_req2_rise");
    pushExp(18, F_TMO, 0, "D_timeout_not_yet");
    pushExp(19, F_TMO, 1, "D_timeout_set");
    pushExp(19, F_REQ, 4, "D_req2_held");
    pushExp(25, F_TMO, 1, "D_timeout_sticky");
    pushExp(25, F_REQ, 4, "D_req2_still");
    pushExp(25, F_BUSY, 0, "D_no_busy");
    for (int r = 0; r <= 26; r++)
      applyStimulus(1'b0, (r == 1) ? 3'b100 : 3'b000, GNT_NONE);

    // Grant to an idle client.
    doReset();
    pushExp(2, F_PROTO, 0, "E_proto_not_yet");
    pushExp(3, F_PROTO, 1, "E_proto_idle_grant");
    pushExp(5, F_PROTO, 1, "E_proto_sticky");
    pushExp(5, F_REQ, 0, "E_no_req");
    for (int r = 0; r <= 6; r++)
      applyStimulus(1'b0, 3'b000, (r == 2) ? GNT_C1 : GNT_NONE);

    // Preemption mid-HOLD, then a clean regrant completes the job.
    doReset();
    pushExp(6, F_BUSY, 1, "F_busy_before_drop");
    pushExp(6, F_PROTO, 0, "F_proto_not_yet");
    pushExp(7, F_PROTO, 1, "F_proto_preempt");
    pushExp(7, F_BUSY, 0, "F_busy_dropped");
    pushExp(7, F_REQ, 1, "F_req_reassert");
    pushExp(7, F_PEND, 1, "F_pend_kept");
    pushExp(9, F_PEND, 1, "F_pend_still");
    pushExp(10, F_BUSY, 1, "F_busy_regrant");
    pushExp(14, F_PEND, 0, "F_pend_done");
    pushDone(14, 3'b001);
    for (int r = 0; r <= 16; r++)
      applyStimulus(1'b0, (r == 1) ? 3'b001 : 3'b000,
                    ((r >= 3 && r <= 5) || (r >= 9 && r <= 13)) ? GNT_C0 : GNT_NONE);

    // Reset mid-HOLD with proto_err already set: everything clears, no done.
    doReset();
    pushExp(3, F_PROTO, 1, "G_proto_set");
    pushExp(5, F_BUSY, 1, "G_busy_in_hold");
    pushResetVals(6, "G_after_rst");
    for (int r = 0; r <= 10; r++)
      applyStimulus(r == 5, (r == 1) ? 3'b001 : 3'b000,
                    (r == 2) ? GNT_C1 : (r >= 3 && r <= 5) ? GNT_C0 : GNT_NONE);

    applyStimulus(1'b0, 3'b000, GNT_NONE);
    applyStimulus(1'b0, 3'b000, GNT_NONE);
    #1;
    foreach (expQ[i]) begin
      total++;
      bad++;
      $display("[TB] FAIL missed_%s: not sampled, want %0d", expQ[i].name, expQ[i].val);
    end
    foreach (doneQ[i]) begin
      total++;
      bad++;
      $display("[TB] FAIL missing_done: got none, want %b at cycle %0d", doneQ[i].val, doneQ[i].cyc);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
